// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: branch FSM encoding, PC reset value and
// branch condition encodings used by both the condition logic and the sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } br_state_t;

  localparam int unsigned PC_RESET = 0;

  typedef enum logic [1:0] {
    COND_ZERO    = 2'b00,
    COND_NONZERO = 2'b01,
    COND_POS     = 2'b10,
    COND_NEG     = 2'b11
  } br_cond_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. With EN=0 no flops are built
// and the count is a constant zero.
module sat_counter #(
  parameter int W  = 16,
  parameter bit EN = 1'b1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  if (EN) begin : g_cnt
    logic [W-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}}))
        count_d = count_q + W'(1);
    end

    always_ff @(posedge clock) begin
      if (clear) count_q <= '0;
      else       count_q <= count_d;
    end

    assign count = count_q;
  end else begin : g_nocnt
    logic unused_in;
    assign unused_in = ^{clock, clear, inc};
    assign count     = '0;
  end

endmodule

// File: rtl/branch_pc_seq.sv
// Branch sequencer and sole PC owner: fetch increment, direct loads and the
// IDLE/EVAL/UPDATE/DONE conditional-branch sequence. Define BRANCH_STATS_EN
// to build the taken/not-taken saturating counters.
module branch_pc_seq
  import cpu_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int OFF_W  = 19,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              inc_pc,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_load_value,
  input  logic              br_start,
  input  logic              con_flag,
  input  logic [OFF_W-1:0]  br_offset,
  output logic [PC_W-1:0]   pc,
  output logic              con_ff,
  output logic              busy,
  output logic              br_done,
  output logic              br_taken,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] not_taken_cnt
);

`ifdef BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  br_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             con_ff_q, con_ff_d;
  logic             br_done_q, br_done_d;
  logic             br_taken_q, br_taken_d;
  logic [PC_W-1:0]  off_sext;

  assign off_sext = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

  // pc_load outranks everything but clear and aborts any sequence in flight,
  // which also blocks the EVAL capture so con_ff keeps its last value.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    off_d      = off_q;
    con_ff_d   = con_ff_q;
    br_done_d  = 1'b0;
    br_taken_d = 1'b0;
    if (pc_load) begin
      pc_d    = pc_load_value;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_start) begin
            state_d = EVAL;
            off_d   = br_offset;
          end else if (inc_pc) begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        EVAL: begin
          con_ff_d = con_flag;
          state_d  = UPDATE;
        end
        UPDATE: begin
          if (con_ff_q) pc_d = pc_q + off_sext;
          state_d    = DONE;
          br_done_d  = 1'b1;
          br_taken_d = con_ff_q;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      pc_q       <= PC_W'(PC_RESET);
      off_q      <= '0;
      con_ff_q   <= 1'b0;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      off_q      <= off_d;
      con_ff_q   <= con_ff_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign pc       = pc_q;
  assign con_ff   = con_ff_q;
  assign busy     = (state_q != IDLE);
  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;

  logic in_done;
  assign in_done = (state_q == DONE);

  sat_counter #(.W(STAT_W), .EN(STATS_EN)) u_taken_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (in_done & con_ff_q),
    .count (taken_cnt)
  );

  sat_counter #(.W(STAT_W), .EN(STATS_EN)) u_not_taken_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (in_done & ~con_ff_q),
    .count (not_taken_cnt)
  );

endmodule

// File: tb/tb_branch_pc_seq.sv
// Directed bench for branch_pc_seq: reset, taken/not-taken branches, wrap,
// abort priority and statistics counters (STAT_W=2).
module tb_branch_pc_seq;

  localparam int PC_W = 32, OFF_W = 19, STAT_W = 2;

  logic              clock = 1'b0;
  logic              clear, inc_pc, pc_load, br_start, con_flag;
  logic [PC_W-1:0]   pc_load_value;
  logic [OFF_W-1:0]  br_offset;
  logic [PC_W-1:0]   pc;
  logic              con_ff, busy, br_done, br_taken;
  logic [STAT_W-1:0] taken_cnt, not_taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_pc_seq #(.PC_W(PC_W), .OFF_W(OFF_W), .STAT_W(STAT_W)) dut (
    .clock(clock), .clear(clear), .inc_pc(inc_pc), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .br_start(br_start), .con_flag(con_flag),
    .br_offset(br_offset), .pc(pc), .con_ff(con_ff), .busy(busy),
    .br_done(br_done), .br_taken(br_taken), .taken_cnt(taken_cnt),
    .not_taken_cnt(not_taken_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] v);
    pc_load = 1'b1; pc_load_value = v;
    step();
    pc_load = 1'b0;
  endtask

  // Full branch: start, EVAL with flag, UPDATE, DONE, back to IDLE.
  task automatic branch(input logic [OFF_W-1:0] off, input logic flag);
    br_start = 1'b1; br_offset = off;
    step();
    br_start = 1'b0; con_flag = flag;
    step();
    con_flag = 1'b0;
    step();
    step();
  endtask

  initial begin
    clear = 1'b1; inc_pc = 0; pc_load = 0; br_start = 0; con_flag = 0;
    pc_load_value = '0; br_offset = '0;
    step();
    clear = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_con_ff", {31'b0, con_ff}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_br_done", {31'b0, br_done}, 0);
    chk("rst_br_taken", {31'b0, br_taken}, 0);
    chk("rst_taken_cnt", {30'b0, taken_cnt}, 0);
    chk("rst_not_taken_cnt", {30'b0, not_taken_cnt}, 0);

    inc_pc = 1'b1;
    step(); step(); step();
    inc_pc = 1'b0;
    chk("inc3_pc", pc, 3);

    // Taken forward branch
    load(32'h10);
    br_start = 1'b1; br_offset = 19'h00005; inc_pc = 1'b1;
    step();
    br_start = 1'b0; inc_pc = 1'b0;
    chk("tk_eval_busy", {31'b0, busy}, 1);
    chk("tk_eval_pc_noinc", pc, 32'h10);
    con_flag = 1'b1;
    step();
    con_flag = 1'b0;
    chk("tk_upd_con_ff", {31'b0, con_ff}, 1);
    chk("tk_upd_pc_hold", pc, 32'h10);
    chk("tk_upd_no_done", {31'b0, br_done}, 0);
    step();
    chk("tk_pc", pc, 32'h15);
    chk("tk_br_done", {31'b0, br_done}, 1);
    chk("tk_br_taken", {31'b0, br_taken}, 1);
    step();
    chk("tk_idle_busy", {31'b0, busy}, 0);
    chk("tk_idle_done", {31'b0, br_done}, 0);

    // Not taken, inc_pc during UPDATE suppressed
    load(32'h10);
    br_start = 1'b1; br_offset = 19'h00005;
    step();
    br_start = 1'b0; con_flag = 1'b0;
    step();
    inc_pc = 1'b1;
    step();
    inc_pc = 1'b0;
    chk("nt_pc", pc, 32'h10);
    chk("nt_br_done", {31'b0, br_done}, 1);
    chk("nt_br_taken", {31'b0, br_taken}, 0);
    chk("nt_con_ff", {31'b0, con_ff}, 0);
    step();

    // Negative offset with wrap, then increment wrap
    load(32'h2);
    branch(19'h7FFFC, 1'b1);
    chk("neg_pc", pc, 32'hFFFF_FFFE);
    inc_pc = 1'b1;
    step(); step();
    inc_pc = 1'b0;
    chk("wrap_pc", pc, 0);

    // Abort in EVAL: con_ff must keep its last value (1)
    br_start = 1'b1; br_offset = 19'h00005;
    step();
    br_start = 1'b0;
    pc_load = 1'b1; pc_load_value = 32'h40; con_flag = 1'b0;
    step();
    pc_load = 1'b0;
    chk("abort_pc", pc, 32'h40);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_no_done", {31'b0, br_done}, 0);
    chk("abort_con_ff", {31'b0, con_ff}, 1);
    step();
    chk("abort_no_done2", {31'b0, br_done}, 0);
    chk("abort_pc_hold", pc, 32'h40);

    // pc_load beats br_start in IDLE
    br_start = 1'b1; pc_load = 1'b1; pc_load_value = 32'h80;
    step();
    br_start = 1'b0; pc_load = 1'b0;
    chk("ld_vs_start_pc", pc, 32'h80);
    chk("ld_vs_start_busy", {31'b0, busy}, 0);

    // Statistics
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("stat_clr_taken", {30'b0, taken_cnt}, 0);
    for (int i = 0; i < 4; i++) branch(19'h00001, 1'b1);
    branch(19'h00001, 1'b0);
    chk("stat_pc", pc, 4);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_sat", {30'b0, taken_cnt}, 3);
    chk("stat_not_taken", {30'b0, not_taken_cnt}, 1);
`else
    chk("stat_taken_off", {30'b0, taken_cnt}, 0);
    chk("stat_not_taken_off", {30'b0, not_taken_cnt}, 0);
`endif

    // clear mid-sequence
    br_start = 1'b1; br_offset = 19'h00003;
    step();
    br_start = 1'b0; con_flag = 1'b1;
    step();
    con_flag = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("midclr_busy", {31'b0, busy}, 0);
    chk("midclr_pc", pc, 0);
    chk("midclr_con_ff", {31'b0, con_ff}, 0);
    chk("midclr_taken", {30'b0, taken_cnt}, 0);
    step();
    chk("midclr_no_done", {31'b0, br_done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_pc_seq.md
# branch_pc_seq

Branch sequencer and program-counter owner for the phase-4 CPU datapath. It sits directly downstream of the conditional-branch evaluation logic. It consumes that logic's single-bit condition result, latches it into the CON flip-flop, and applies the conditional PC update for `brzr`/`brnz`/`brpl`/`brmi`. It also performs the ordinary fetch-time PC increment and direct PC loads (jump/jal), so it is the only writer of PC.

## Interface
Parameters:
- `PC_W`, 32: PC and bus width
- `OFF_W`, 19: branch offset field width (IR C field)
- `STAT_W`, 16: statistics counter width (only with `BRANCH_STATS_EN`)

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, all state updates on rising edge
- `clear` in 1: synchronous active-high reset
- `inc_pc` in 1: PC <= PC + 1 (fetch), honoured only in IDLE
- `pc_load` in 1: PC <= `pc_load_value`
- `pc_load_value` in PC_W: direct load value (from bus)
- `br_start` in 1: begin branch sequence, accepted only in IDLE
- `con_flag` in 1: condition result from condition logic
- `br_offset` in OFF_W: signed offset C, sign-extended to PC_W
- `pc` out PC_W: current PC
- `con_ff` out 1: latched CON flip-flop
- `busy` out 1: high in EVAL, UPDATE, DONE
- `br_done` out 1: one-cycle pulse in DONE
- `br_taken` out 1: valid with `br_done`, equals `con_ff`
- `taken_cnt` out STAT_W: taken branches (macro only)
- `not_taken_cnt` out STAT_W: not-taken branches (macro only)

## Operation
- FSM states: IDLE, EVAL, UPDATE, DONE.
- IDLE -> EVAL on `br_start`.
  - `br_offset` is captured into an internal register on acceptance.
  - `inc_pc` asserted in the same cycle is ignored.
- EVAL: `con_ff <= con_flag`. `con_flag` must be valid during this cycle, because the bus carries Ra here. -> UPDATE.
- UPDATE: if `con_ff`, PC <= PC + sext(offset_reg); otherwise PC holds. -> DONE.
  - PC already points past the branch instruction because it was incremented at fetch.
- DONE: `br_done` = 1, `br_taken` = `con_ff`. -> IDLE.
- Arithmetic is modulo 2^PC_W:
  - increment from 0xFFFFFFFF wraps to 0;
  - a negative offset below 0 wraps.
- Priority per cycle, highest first: `clear` > `pc_load` > branch UPDATE > `inc_pc`.
- `pc_load` in any non-IDLE state aborts the sequence:
  - PC loads `pc_load_value`;
  - FSM -> IDLE;
  - no `br_done` pulse is issued;
  - `con_ff` keeps its last value.
- `br_start` while busy is ignored (no queueing).
- `inc_pc` while busy is ignored.
- `con_ff` holds between branches; it changes only in EVAL or on `clear`.

## Timing
- Reset values:
  - `pc` = 0, `con_ff` = 0, `busy` = 0, `br_done` = 0, `br_taken` = 0;
  - stat counters = 0;
  - FSM = IDLE.
- `clear` mid-sequence returns to IDLE next edge. No `br_done`.
- Latency:
  - `br_start` at edge N gives EVAL at N+1;
  - PC updated at edge N+2;
  - `br_done` high during cycle N+3;
  - next `br_start` is accepted at edge N+4.
- `inc_pc` and `pc_load` take effect at the next edge, with 1-cycle latency.
- All outputs are registered except `busy`, which is decoded from FSM state.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `taken_cnt`/`not_taken_cnt` increment in DONE according to `con_ff`;
  - both saturate at all-ones;
  - both clear on `clear`.
- Undefined: counter ports remain and are tied to 0, and no counter flops are inferred.

## Structure
- Shared package `cpu_pkg` holds:
  - FSM state encoding typedef `br_state_t`: IDLE=0, EVAL=1, UPDATE=2, DONE=3;
  - `PC_RESET` (0);
  - the branch condition encodings (00 zero, 01 nonzero, 10 positive, 11 negative), also used by the condition logic.
- One sub-module: `sat_counter` (STAT_W, increment enable, saturate), instantiated twice under the macro.

## Test plan
- Reset: drive `clear` 1 cycle -> `pc`=0, `con_ff`=0, `busy`=0. Apply `inc_pc` x3 -> `pc`=3.
- Taken forward branch: `pc`=0x10, `br_offset`=0x00005, `con_flag`=1 in EVAL -> `pc`=0x15 at N+2, `br_done`/`br_taken`=1 at N+3.
- Not taken, with busy-suppression check:
  - stimulus: `pc`=0x10, `con_flag`=0, and `inc_pc` pulsed during UPDATE;
  - response: `pc` stays 0x10, `br_taken`=0, `con_ff`=0.
- Negative offset and wrap:
  - `pc`=0x2, `br_offset`=0x7FFFC (-4), taken -> `pc`=0xFFFFFFFE;
  - then `inc_pc` x2 -> `pc`=0.
- Abort: `pc_load`=1 with `pc_load_value`=0x40 during EVAL -> `pc`=0x40, FSM IDLE next cycle, no `br_done`. Also `br_start` in the same cycle as `pc_load` in IDLE -> `pc_load` wins.
- Stats (`BRANCH_STATS_EN`, STAT_W=2):
  - 4 taken branches -> `taken_cnt`=3 (saturated);
  - 1 not-taken -> `not_taken_cnt`=1;
  - macro undefined -> both stay 0.
